ser2par_rx_ctrl: RTL

//   Receive sequencer for the 8-bit serial-to-parallel shift register (ser2par).

---
 rtl/ser2par_pkg.sv | 22 ++
 rtl/ser2par.sv | 29 ++
 rtl/ser2par_baud_cnt.sv | 35 +++
 rtl/ser2par_rx_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ser2par_pkg.sv
// ============================================================================
//  Module   : ser2par_pkg
//  Purpose  : Shared types and constants for the ser2par receiver slice.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ser2par_pkg;

    localparam int SER_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/ser2par.sv
// ============================================================================
//  Module   : ser2par
//  Purpose  : 8-bit serial-to-parallel shifter, LSB received first.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ser2par
    import ser2par_pkg::*;
(
    input  logic                 Clk,
    input  logic                 RstB,
    input  logic                 SerDataIn,
    input  logic                 SerDataEn,
    output logic [SER_WIDTH-1:0] ParDataOut
);

    // New bits enter at the MSB so the first bit ends up in bit 0.
    always_ff @(posedge Clk or negedge RstB) begin
        if (!RstB) begin
            ParDataOut <= '0;
        end else if (SerDataEn) begin
            ParDataOut <= {SerDataIn, ParDataOut[SER_WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/ser2par_baud_cnt.sv
// ============================================================================
//  Module   : ser2par_baud_cnt
//  Purpose  : Loadable down-counter; tick flags a count of zero.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ser2par_baud_cnt #(
    parameter int CNT_W = 10
) (
    input  logic             Clk,
    input  logic             RstB,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] r_count;

    // Holds at zero while the FSM is not timing anything.
    always_ff @(posedge Clk or negedge RstB) begin
        if (!RstB) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign tick = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ser2par_rx_ctrl.sv
// ============================================================================
//  Module   : ser2par_rx_ctrl
//  Purpose  : 8N1 receive sequencer driving the ser2par shifter, with a
//             valid/ready output stage and framing/overrun flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ser2par_rx_ctrl
    import ser2par_pkg::*;
#(
    parameter int ClkPerBit = 868,
    parameter int BitLen    = 8
) (
    input  logic                 Clk,
    input  logic                 RstB,
    input  logic                 RxLine,
    output logic                 ShDataOut,
    output logic                 ShEnOut,
    input  logic [SER_WIDTH-1:0] ShParIn,
    output logic [SER_WIDTH-1:0] RxData,
    output logic                 RxValid,
    input  logic                 RxReady,
    output logic                 FrameErr,
    output logic                 OverrunErr
);

    localparam int CNT_W = $clog2(ClkPerBit);
    localparam int BIT_W = $clog2(BitLen + 1);

    localparam logic [CNT_W-1:0] c_half_load = CNT_W'(ClkPerBit / 2 - 1);
    localparam logic [CNT_W-1:0] c_full_load = CNT_W'(ClkPerBit - 1);
    localparam logic [BIT_W-1:0] c_last_bit  = BIT_W'(BitLen - 1);

    rx_state_t        r_state;
    logic [1:0]       r_sync;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             w_line;
    logic             w_tick;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;

    always_ff @(posedge Clk or negedge RstB) begin
        if (!RstB) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RxLine};
        end
    end

    assign w_line = r_sync[1];

    // Counter reloads coincide with the FSM transitions below.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = c_full_load;
        case (r_state)
            IDLE: begin
                if (!w_line) begin
                    w_load     = 1'b1;
                    w_load_val = c_half_load;
                end
            end
            START:   w_load = w_tick && !w_line;
            DATA:    w_load = w_tick;
            default: w_load = 1'b0;
        endcase
    end

    ser2par_baud_cnt #(
        .CNT_W (CNT_W)
    ) u_baud_cnt (
        .Clk      (Clk),
        .RstB     (RstB),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (w_tick)
    );

    always_ff @(posedge Clk or negedge RstB) begin
        if (!RstB) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            ShDataOut  <= 1'b0;
            ShEnOut    <= 1'b0;
            RxData     <= '0;
            RxValid    <= 1'b0;
            FrameErr   <= 1'b0;
            OverrunErr <= 1'b0;
        end else begin
            ShEnOut    <= 1'b0;
            ShDataOut  <= 1'b0;
            FrameErr   <= 1'b0;
            OverrunErr <= 1'b0;
            if (RxValid && RxReady) begin
                RxValid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (!w_line) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (!w_line) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        ShEnOut   <= 1'b1;
                        ShDataOut <= w_line;
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (w_line) begin
                            // A same-cycle accept frees the slot for the new byte.
                            if (!RxValid || RxReady) begin
                                RxData  <= ShParIn;
                                RxValid <= 1'b1;
                            end else begin
                                OverrunErr <= 1'b1;
                            end
                            r_state <= IDLE;
                        end else begin
                            FrameErr <= 1'b1;
                            r_state  <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (w_line) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
